// File: rtl/addr_gen.sv
// 6502 address generation: PC, ADL/ADH effective-address temporaries, stack and vector addresses.
// Latency: state and addr_sel update on posedge; addr0..addr3 follow combinationally in the same cycle.
// Backpressure: none; the sequencer drives one command set per cycle and it always completes.
module addr_gen #(
    parameter logic [15:0] RESET_PC = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic [7:0]  idx,
    input  logic [7:0]  sp,
    input  logic [1:0]  sel_req,
    input  logic        pc_inc,
    input  logic        pc_load,
    input  logic        adl_load,
    input  logic        adh_load,
    input  logic        ad_zp,
    input  logic        idx_add,
    input  logic        carry_fix,
    input  logic [1:0]  vec_sel,
    input  logic        vec_hi,
    output logic [1:0]  addr_sel,
    output logic [15:0] addr0,
    output logic [15:0] addr1,
    output logic [15:0] addr2,
    output logic [15:0] addr3,
    output logic        page_cross
);

    logic [15:0] pc;
    logic [7:0]  adl;
    logic [7:0]  adh;
    logic [7:0]  adl_base;
    logic [8:0]  adl_sum;
    logic [15:0] vec_off;

    always_comb begin
        adl_base = adl_load ? din : adl;
        adl_sum  = {1'b0, adl_base} + {1'b0, idx};
    end

    // Reserved vector code 3 aliases IRQ/BRK; max result is FFFF so no wrap is possible.
    always_comb begin
        vec_off = 16'd4;
        case (vec_sel)
            2'd0:    vec_off = 16'd0;
            2'd1:    vec_off = 16'd2;
            default: vec_off = 16'd4;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            adl        <= 8'h00;
            adh        <= 8'h00;
            page_cross <= 1'b0;
            addr_sel   <= 2'b11;
        end else begin
            addr_sel <= sel_req;

            if (pc_load)
                pc <= {adh, adl};
            else if (pc_inc)
                pc <= pc + 16'd1;

            if (idx_add)
                adl <= adl_sum[7:0];
            else if (adl_load)
                adl <= din;

            // Fixup uses the carry from the previous add, even if a new add lands this cycle.
            if (adh_load)
                adh <= din;
            else if (ad_zp)
                adh <= 8'h00;
            else if (carry_fix)
                adh <= adh + {7'b0, page_cross};

            if (idx_add)
                page_cross <= adl_sum[8];
            else if (carry_fix)
                page_cross <= 1'b0;
        end
    end

    assign addr0 = pc;
    assign addr1 = {adh, adl};
    assign addr2 = {8'h01, sp};
    assign addr3 = 16'hFFFA + vec_off + {15'b0, vec_hi};

endmodule

// File: tb/tb_addr_gen.sv
// Directed self-checking bench for addr_gen.
module tb_addr_gen;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic [7:0]  idx;
    logic [7:0]  sp;
    logic [1:0]  sel_req;
    logic        pc_inc;
    logic        pc_load;
    logic        adl_load;
    logic        adh_load;
    logic        ad_zp;
    logic        idx_add;
    logic        carry_fix;
    logic [1:0]  vec_sel;
    logic        vec_hi;
    logic [1:0]  addr_sel;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [15:0] addr2;
    logic [15:0] addr3;
    logic        page_cross;

    int checks = 0;
    int errors = 0;

    addr_gen #(.RESET_PC(16'hFFFC)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .idx(idx), .sp(sp),
        .sel_req(sel_req), .pc_inc(pc_inc), .pc_load(pc_load),
        .adl_load(adl_load), .adh_load(adh_load), .ad_zp(ad_zp),
        .idx_add(idx_add), .carry_fix(carry_fix), .vec_sel(vec_sel),
        .vec_hi(vec_hi), .addr_sel(addr_sel), .addr0(addr0), .addr1(addr1),
        .addr2(addr2), .addr3(addr3), .page_cross(page_cross)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        pc_inc = 0; pc_load = 0; adl_load = 0; adh_load = 0;
        ad_zp = 0; idx_add = 0; carry_fix = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic load_ad(input logic [7:0] hi, input logic [7:0] lo);
        din = lo; adl_load = 1; tick();
        din = hi; adh_load = 1; tick();
    endtask

    initial begin
        clr();
        rst_n = 0; din = 0; idx = 0; sp = 8'hFF; sel_req = 0;
        vec_sel = 2'd1; vec_hi = 1'b0;
        #12;
        chk("rst_pc", addr0, 16'hFFFC);
        chk("rst_ad", addr1, 16'h0000);
        chk("rst_sel", {14'b0, addr_sel}, 16'd3);
        chk("rst_pcross", {15'b0, page_cross}, 16'd0);
        chk("vec_reset_lo", addr3, 16'hFFFC);
        vec_hi = 1;
        #1;
        chk("vec_reset_hi", addr3, 16'hFFFD);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // Build PC=1234 and a pending carry, then reset mid-cycle.
        load_ad(8'h12, 8'h34);
        pc_load = 1; tick();
        chk("pc_1234", addr0, 16'h1234);
        sel_req = 2'd1; idx = 8'hF0; idx_add = 1; tick();
        chk("pre_rst_pcross", {15'b0, page_cross}, 16'd1);
        chk("pre_rst_sel", {14'b0, addr_sel}, 16'd1);
        #2 rst_n = 0;
        #1;
        chk("midrst_pc", addr0, 16'hFFFC);
        chk("midrst_sel", {14'b0, addr_sel}, 16'd3);
        chk("midrst_pcross", {15'b0, page_cross}, 16'd0);
        chk("midrst_ad", addr1, 16'h0000);
        @(negedge clk);
        rst_n = 1; sel_req = 0;
        @(posedge clk); #1;

        // PC increment wrap.
        load_ad(8'hFF, 8'hFE);
        pc_load = 1; tick();
        chk("pc_fffe", addr0, 16'hFFFE);
        pc_inc = 1; tick(); chk("pc_inc1", addr0, 16'hFFFF);
        pc_inc = 1; tick(); chk("pc_inc2", addr0, 16'h0000);
        pc_inc = 1; tick(); chk("pc_inc3", addr0, 16'h0001);
        load_ad(8'hC0, 8'h00);
        pc_inc = 1; pc_load = 1; tick();
        chk("pc_load_prio", addr0, 16'hC000);
        tick();
        chk("pc_hold", addr0, 16'hC000);

        // Abs,X without page cross.
        din = 8'h80; adl_load = 1; tick();
        din = 8'h12; adh_load = 1; idx = 8'h05; idx_add = 1; tick();
        chk("absx_nc", addr1, 16'h1285);
        chk("absx_nc_pc", {15'b0, page_cross}, 16'd0);
        carry_fix = 1; tick();
        chk("absx_nc_fix", addr1, 16'h1285);

        // Abs,X with page cross.
        load_ad(8'h12, 8'hF0);
        idx = 8'h20; idx_add = 1; tick();
        chk("absx_c", addr1, 16'h1210);
        chk("absx_c_pc", {15'b0, page_cross}, 16'd1);
        carry_fix = 1; tick();
        chk("absx_c_fix", addr1, 16'h1310);
        chk("absx_c_fix_pc", {15'b0, page_cross}, 16'd0);

        // ADH wrap FF -> 00 on fixup.
        load_ad(8'hFF, 8'hF0);
        idx_add = 1; tick();
        chk("wrap_pre", addr1, 16'hFF10);
        carry_fix = 1; tick();
        chk("wrap_fix", addr1, 16'h0010);

        // Load beats carry_fix, carry still cleared.
        load_ad(8'h12, 8'hF0);
        idx_add = 1; tick();
        din = 8'h55; adh_load = 1; carry_fix = 1; tick();
        chk("load_vs_fix", addr1, 16'h5510);
        chk("load_vs_fix_pc", {15'b0, page_cross}, 16'd0);

        // idx_add with carry_fix: old carry to ADH, new carry captured.
        load_ad(8'h12, 8'hF0);
        idx = 8'h20; idx_add = 1; tick();
        idx = 8'hF0; idx_add = 1; carry_fix = 1; tick();
        chk("add_fix", addr1, 16'h1300);
        chk("add_fix_pc", {15'b0, page_cross}, 16'd1);

        // ZP,X wraps within page zero.
        din = 8'hF0; idx = 8'h20; adl_load = 1; idx_add = 1; ad_zp = 1; tick();
        chk("zpx", addr1, 16'h0010);
        chk("zpx_pc", {15'b0, page_cross}, 16'd1);
        tick();
        chk("zpx_hold", addr1, 16'h0010);

        // Stack, select register, vectors.
        sp = 8'hFD; sel_req = 2'd2;
        #1;
        chk("sel_before_edge", {14'b0, addr_sel}, 16'd0);
        chk("stack", addr2, 16'h01FD);
        tick();
        chk("sel_after_edge", {14'b0, addr_sel}, 16'd2);
        vec_sel = 2'd0; vec_hi = 0; #1; chk("vec_nmi", addr3, 16'hFFFA);
        vec_sel = 2'd2; #1; chk("vec_irq", addr3, 16'hFFFE);
        vec_sel = 2'd3; #1; chk("vec_rsvd", addr3, 16'hFFFE);
        vec_hi = 1; #1; chk("vec_rsvd_hi", addr3, 16'hFFFF);
        vec_sel = 2'd0; #1; chk("vec_nmi_hi", addr3, 16'hFFFB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
